cva5_fifo_counted: RTL
======================

Name: cva5_fifo_counted

Overview:
- Next-generation small FIFO for the core.
- Flat-port, first-word-fall-through buffer with a parametrised width and an arbitrary depth; depth is not rounded up to a power of two.
- Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, and overflow/underflow protection with sticky error flags.
- Used between issue/writeback stages and load/store queues where units need occupancy-based backpressure and pipeline-flush support.

Parameters:
- DATA_WIDTH, 32, width of each entry in bits (>=1).
- FIFO_DEPTH, 4, number of entries (>=1, any integer).
- ALMOST_FULL_THRESHOLD, FIFO_DEPTH-1, almost_full asserts when count >= this value (legal range 1..FIFO_DEPTH).
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when count <= this value (legal range 0..FIFO_DEPTH-1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  enqueue request.
- pop  input  1  dequeue request.
- flush  input  1  synchronous clear of all contents.
- clear_errors  input  1  synchronous clear of the sticky error flags.
- data_in  input  DATA_WIDTH  entry to enqueue.
- data_out  output  DATA_WIDTH  head entry (first-word-fall-through).
- valid  output  1  FIFO non-empty.
- full  output  1  count == FIFO_DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_THRESHOLD.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESHOLD.
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Storage is FIFO_DEPTH x DATA_WIDTH and is not reset.
- State is rd_ptr, wr_ptr (width max(1,$clog2(FIFO_DEPTH))), count, overflow and underflow.
- Pointers wrap explicitly from FIFO_DEPTH-1 to 0.
- Reset (async assert, any cycle):
  - rd_ptr, wr_ptr, count, overflow and underflow go to 0 immediately.
  - Outputs under reset: valid=0, full=0, almost_full=0, almost_empty=1, data_out=0.
  - Takes effect mid-operation with no completion of in-flight push or pop.
- Acceptance rules, evaluated each cycle when not flushing:
  - pop_ok = pop & (count != 0). There is no bypass: a pop to an empty FIFO is rejected even if push is asserted in the same cycle.
  - push_ok = push & ((count != FIFO_DEPTH) | pop_ok). Push to a full FIFO is accepted when a pop is accepted in the same cycle.
- Updates on the edge:
  - push_ok writes mem[wr_ptr] <= data_in and advances wr_ptr.
  - pop_ok advances rd_ptr.
  - count <= count + push_ok - pop_ok.
- Errors:
  - push & ~push_ok sets overflow.
  - pop & ~pop_ok sets underflow.
  - Both flags stay set until rst or clear_errors.
  - If clear_errors coincides with a new error, the new error wins (flag stays 1).
- Flush (highest priority below rst):
  - rd_ptr, wr_ptr and count go to 0.
  - push and pop in the same cycle are ignored and set no error flags.
  - Storage contents are left stale.
- Outputs are combinational from registered state only (no input-to-output paths):
  - valid = (count != 0).
  - data_out = valid ? mem[rd_ptr] : 0.
  - full, almost_full and almost_empty are compares on count.
- Latency:
  - An entry pushed at edge N is visible on data_out/valid after edge N, with 1-cycle latency when the FIFO was empty.
  - Pop removes the head at the edge; the next entry appears after that edge.
- FIFO_DEPTH==1:
  - Pointers are a constant 0; count is 1 bit.
  - Simultaneous push and pop while full replaces the entry; count stays 1.
- Simulation assertions:
  - Flag overflow and underflow.
  - Flag any parameter outside its legal range at elaboration.

Test Plan:
- DEPTH=3, DATA_WIDTH=8, reset released. Push 0x11, 0x22, 0x33 on consecutive cycles -> count 1,2,3; full=1 after 3rd edge; almost_full=1 after 2nd edge; then pop 3x -> data_out 0x11, 0x22, 0x33 in order; valid=0 and almost_empty=1 at the end.
- Wrap-around: DEPTH=3, perform 7 push/pop pairs with values 1..7 at count=1 -> data_out sequence is preserved and count stays at 1 throughout.
- Full FIFO with push 0x44 + pop in the same cycle -> 0x44 accepted, count stays 3, overflow=0. Push alone while full -> count=3, overflow=1, contents unchanged.
- Empty FIFO with pop+push 0x55 -> underflow=1, count=1, data_out=0x55 next cycle. Then clear_errors -> underflow=0.
- count=2 with flush+push+pop asserted together -> count=0, valid=0, data_out=0, no error flags. A push afterwards yields its data at the head.
- Assert rst asynchronously between edges with count=2 and overflow=1 -> count=0, overflow=0, valid=0 before the next clk edge. After deassertion, normal pushes resume.

Source files
------------

// File: rtl/cva5_fifo_counted.sv
// rtl/cva5_fifo_counted.sv - counted first-word-fall-through FIFO with thresholds, flush and sticky errors
module cva5_fifo_counted #(
    parameter int DATA_WIDTH             = 32,
    parameter int FIFO_DEPTH             = 4,
    parameter int ALMOST_FULL_THRESHOLD  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clear_errors,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    // Parameter legality, reported at elaboration
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("cva5_fifo_counted: DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("cva5_fifo_counted: FIFO_DEPTH must be >= 1");
    end
    if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > FIFO_DEPTH) begin : g_bad_af
        $error("cva5_fifo_counted: ALMOST_FULL_THRESHOLD out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_THRESHOLD < 0 || ALMOST_EMPTY_THRESHOLD > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("cva5_fifo_counted: ALMOST_EMPTY_THRESHOLD out of range 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_ok, pop_ok, wr_en;

    // Explicit wrap so non-power-of-two depths never index past the last entry
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance, pointer/count next state and sticky error flags
    always_comb begin
        pop_ok      = pop && (count_q != '0);
        push_ok     = push && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
        wr_en       = push_ok && !flush;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q && !clear_errors;
        underflow_d = underflow_q && !clear_errors;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            // A new error outranks a coincident clear
            if (push && !push_ok) overflow_d = 1'b1;
            if (pop && !pop_ok)   underflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; stale entries are masked by valid
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

    // Outputs derive only from registered state
    always_comb begin
        valid        = (count_q != '0);
        data_out     = valid ? mem_q[rd_ptr_q] : '0;
        full         = (count_q == CW'(FIFO_DEPTH));
        almost_full  = (count_q >= CW'(ALMOST_FULL_THRESHOLD));
        almost_empty = (count_q <= CW'(ALMOST_EMPTY_THRESHOLD));
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

`ifndef SYNTHESIS
    // Report rejected requests as they happen
    always @(posedge clk) begin
        if (!rst && !flush && push && !push_ok) $warning("cva5_fifo_counted: push rejected (overflow)");
        if (!rst && !flush && pop && !pop_ok)   $warning("cva5_fifo_counted: pop rejected (underflow)");
    end
`endif

endmodule
